nn_config_sequencer: RTL

- Streams weight/bias configuration words into the accelerator's per-layer neuron memories without per-word software addressing.
- Sits between the AXI-lite/DMA config path and the layer weight/bias memories.
- Auto-sequences layer -> neuron -> weight index -> bias.
- Replaces the software loop of layer-number, neuron-number and weight/bias register writes, one word per cycle.

---
 rtl/nn_cfg_pkg.sv | 25 ++
 rtl/nn_cfg_counter.sv | 70 +++++++
 rtl/nn_config_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nn_cfg_pkg.sv
// Shared types, widths and count-table helper for the NN configuration sequencer.
package nn_cfg_pkg;

  localparam int unsigned LAYER_W     = 4;
  localparam int unsigned NEURON_W    = 16;
  localparam int unsigned COUNT_W     = 16;
  localparam int unsigned MAX_LAYERS  = 15;
  localparam int unsigned COUNT_VEC_W = MAX_LAYERS * COUNT_W;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadB,
    StCheck,
    StFinish
  } state_e;

  // Field idx of a packed count table (layer 1 in the LSBs); out-of-range reads as 0.
  function automatic logic [COUNT_W-1:0] get_count(input logic [COUNT_VEC_W-1:0] vec,
                                                   input logic [LAYER_W-1:0]     idx);
    if (32'(idx) >= MAX_LAYERS) return '0;
    return vec[32'(idx)*COUNT_W +: COUNT_W];
  endfunction

endpackage

// File: rtl/nn_cfg_counter.sv
// Nested layer/neuron/weight-index counter with last-element flags for the config sequencer.
module nn_cfg_counter
  import nn_cfg_pkg::*;
#(
  parameter int unsigned                    NUM_LAYERS    = 4,
  parameter logic [NUM_LAYERS*COUNT_W-1:0] LAYER_NEURONS = {16'd10, 16'd10, 16'd30, 16'd30},
  parameter logic [NUM_LAYERS*COUNT_W-1:0] LAYER_WEIGHTS = {16'd10, 16'd30, 16'd30, 16'd784},
  parameter int unsigned                    ADDR_WIDTH    = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_inc_w,
  input  logic                  i_inc_b,
  output logic [LAYER_W-1:0]    o_layer,
  output logic [NEURON_W-1:0]   o_neuron,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last_w,
  output logic                  o_last_n,
  output logic                  o_last_l
);

  localparam logic [COUNT_VEC_W-1:0] NeuronsExt = COUNT_VEC_W'(LAYER_NEURONS);
  localparam logic [COUNT_VEC_W-1:0] WeightsExt = COUNT_VEC_W'(LAYER_WEIGHTS);

  logic [LAYER_W-1:0]  r_layer;
  logic [NEURON_W-1:0] r_neuron;
  logic [COUNT_W-1:0]  r_widx;
  logic [LAYER_W-1:0]  w_idx;
  logic [COUNT_W-1:0]  w_n_cnt;
  logic [COUNT_W-1:0]  w_w_cnt;

  assign w_idx    = r_layer - LAYER_W'(1);
  assign w_n_cnt  = get_count(NeuronsExt, w_idx);
  assign w_w_cnt  = get_count(WeightsExt, w_idx);
  assign o_last_w = (r_widx == w_w_cnt - COUNT_W'(1));
  assign o_last_n = (r_neuron == w_n_cnt - NEURON_W'(1));
  assign o_last_l = (r_layer == LAYER_W'(NUM_LAYERS));
  assign o_layer  = r_layer;
  assign o_neuron = r_neuron;
  assign o_addr   = r_widx[ADDR_WIDTH-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_layer  <= '0;
      r_neuron <= '0;
      r_widx   <= '0;
    end else if (i_clear) begin
      r_layer  <= LAYER_W'(1);
      r_neuron <= '0;
      r_widx   <= '0;
    end else begin
      if (i_inc_w) r_widx <= o_last_w ? '0 : r_widx + COUNT_W'(1);
      if (i_inc_b) begin
        if (o_last_n) begin
          r_neuron <= '0;
          if (!o_last_l) r_layer <= r_layer + LAYER_W'(1);
        end else begin
          r_neuron <= r_neuron + NEURON_W'(1);
        end
      end
    end
  end

  // Zero counts are illegal; layer 0 only occurs while idle after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && r_layer != '0) assert (w_n_cnt != '0 && w_w_cnt != '0);
  end

endmodule

// File: rtl/nn_config_sequencer.sv
// Streams weight/bias words into per-layer neuron memories, auto-sequencing layer/neuron/index.
// Optional end-of-run checksum word enabled by defining NN_CFG_CHECKSUM_EN.
module nn_config_sequencer
  import nn_cfg_pkg::*;
#(
  parameter int unsigned                    DATA_WIDTH    = 16,
  parameter int unsigned                    NUM_LAYERS    = 4,
  parameter logic [NUM_LAYERS*COUNT_W-1:0] LAYER_NEURONS = {16'd10, 16'd10, 16'd30, 16'd30},
  parameter logic [NUM_LAYERS*COUNT_W-1:0] LAYER_WEIGHTS = {16'd10, 16'd30, 16'd30, 16'd784},
  parameter int unsigned                    ADDR_WIDTH    = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] i_cfg_data,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  output logic [LAYER_W-1:0]    o_wr_layer,
  output logic [NEURON_W-1:0]   o_wr_neuron,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_weight_wen,
  output logic                  o_bias_wen,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_done_sticky,
`ifdef NN_CFG_CHECKSUM_EN
  output logic                  o_cksum_err,
`endif
  output logic                  o_aborted
);

`ifdef NN_CFG_CHECKSUM_EN
  localparam state_e AfterBiasState = StCheck;
`else
  localparam state_e AfterBiasState = StFinish;
`endif

  logic [1:0]            r_rst_sync;
  logic                  w_rst;
  state_e                r_state, w_state_next;
  logic                  w_start, w_abort, w_finish, w_inc_w, w_inc_b;
  logic [LAYER_W-1:0]    w_layer;
  logic [NEURON_W-1:0]   w_neuron;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_last_w, w_last_n, w_last_l;
  logic [LAYER_W-1:0]    r_wr_layer;
  logic [NEURON_W-1:0]   r_wr_neuron;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_weight_wen, r_bias_wen, r_done, r_done_sticky, r_aborted;

  // Asynchronous assert, synchronous release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rst_sync <= 2'b11;
    else       r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  nn_cfg_counter #(
    .NUM_LAYERS   (NUM_LAYERS),
    .LAYER_NEURONS(LAYER_NEURONS),
    .LAYER_WEIGHTS(LAYER_WEIGHTS),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_counter (
    .i_clk   (i_clk),
    .i_rst   (w_rst),
    .i_clear (w_start),
    .i_inc_w (w_inc_w),
    .i_inc_b (w_inc_b),
    .o_layer (w_layer),
    .o_neuron(w_neuron),
    .o_addr  (w_addr),
    .o_last_w(w_last_w),
    .o_last_n(w_last_n),
    .o_last_l(w_last_l)
  );

  // Abort outranks acceptance in every loading state.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_finish     = 1'b0;
    w_inc_w      = 1'b0;
    w_inc_b      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_start      = 1'b1;
          w_state_next = StLoadW;
        end
      end
      StLoadW: begin
        if (i_abort) begin
          w_abort      = 1'b1;
          w_state_next = StIdle;
        end else if (i_cfg_valid) begin
          w_inc_w = 1'b1;
          if (w_last_w) w_state_next = StLoadB;
        end
      end
      StLoadB: begin
        if (i_abort) begin
          w_abort      = 1'b1;
          w_state_next = StIdle;
        end else if (i_cfg_valid) begin
          w_inc_b      = 1'b1;
          w_state_next = (!w_last_n || !w_last_l) ? StLoadW : AfterBiasState;
        end
      end
      StCheck: begin
        if (i_abort) begin
          w_abort      = 1'b1;
          w_state_next = StIdle;
        end else if (i_cfg_valid) begin
          w_state_next = StFinish;
        end
      end
      StFinish: begin
        w_state_next = StIdle;
        if (i_abort) w_abort  = 1'b1;
        else         w_finish = 1'b1;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state       <= StIdle;
      r_wr_layer    <= '0;
      r_wr_neuron   <= '0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_weight_wen  <= 1'b0;
      r_bias_wen    <= 1'b0;
      r_done        <= 1'b0;
      r_done_sticky <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_weight_wen <= w_inc_w;
      r_bias_wen   <= w_inc_b;
      r_done       <= w_finish;
      if (w_inc_w || w_inc_b) begin
        r_wr_layer  <= w_layer;
        r_wr_neuron <= w_neuron;
        r_wr_addr   <= w_addr;
        r_wr_data   <= i_cfg_data;
      end
      if (w_start) begin
        r_done_sticky <= 1'b0;
        r_aborted     <= 1'b0;
      end
      if (w_finish) r_done_sticky <= 1'b1;
      if (w_abort)  r_aborted     <= 1'b1;
    end
  end

`ifdef NN_CFG_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [15:0] w_word16;
  logic        w_check_acc;
  logic        r_cksum_err;

  assign w_word16    = 16'(i_cfg_data);
  assign w_check_acc = (r_state == StCheck) && i_cfg_valid && !i_abort;

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_sum       <= '0;
      r_cksum_err <= 1'b0;
    end else if (w_start) begin
      r_sum       <= '0;
      r_cksum_err <= 1'b0;
    end else begin
      if (w_inc_w || w_inc_b) r_sum <= r_sum + w_word16;
      if (w_check_acc && (w_word16 != r_sum)) r_cksum_err <= 1'b1;
    end
  end
  assign o_cksum_err = r_cksum_err;
`endif

  assign o_cfg_ready   = (r_state == StLoadW) || (r_state == StLoadB) || (r_state == StCheck);
  assign o_busy        = o_cfg_ready;
  assign o_wr_layer    = r_wr_layer;
  assign o_wr_neuron   = r_wr_neuron;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_weight_wen  = r_weight_wen;
  assign o_bias_wen    = r_bias_wen;
  assign o_done        = r_done;
  assign o_done_sticky = r_done_sticky;
  assign o_aborted     = r_aborted;

endmodule
